// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Opcode encoding and shared constants for the ula_core ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    localparam int ULA_OPW = 3;

    typedef enum logic [ULA_OPW-1:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_ADDSUB = 3'b010,
        OP_XOR    = 3'b011,
        OP_NOR    = 3'b100,
        OP_NAND   = 3'b101,
        OP_PASSA  = 3'b110,
        OP_SLT    = 3'b111
    } ula_op_e;

endpackage
`default_nettype wire

// File: rtl/ula_bit_slice.sv
`default_nettype none
// ============================================================================
// Module      : ula_bit_slice
// Description : Combinational 1-bit ALU slice (logic ops plus full adder).
// Revision    : 1.0 - initial release
// ============================================================================
module ula_bit_slice
    import ula_pkg::*;
(
    input  logic [ULA_OPW-1:0] op,
    input  logic               a_i,
    input  logic               b_i,
    input  logic               c_i,
    input  logic               addsub,
    output logic               r_i,
    output logic               c_o,
    output logic               s_i
);

    logic w_bb;

    assign w_bb = addsub ? ~b_i : b_i;
    assign s_i  = a_i ^ w_bb ^ c_i;
    assign c_o  = (a_i & w_bb) | (a_i & c_i) | (w_bb & c_i);

    // SLT yields 0 here; the top level supplies bit 0 of the SLT result.
    always_comb begin
        r_i = 1'b0;
        case (ula_op_e'(op))
            OP_AND:    r_i = a_i & b_i;
            OP_OR:     r_i = a_i | b_i;
            OP_ADDSUB: r_i = s_i;
            OP_XOR:    r_i = a_i ^ b_i;
            OP_NOR:    r_i = ~(a_i | b_i);
            OP_NAND:   r_i = ~(a_i & b_i);
            OP_PASSA:  r_i = a_i;
            OP_SLT:    r_i = 1'b0;
            default:   r_i = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ula_core.sv
`default_nettype none
// ============================================================================
// Module      : ula_core
// Description : Registered ripple-slice integer ALU with carry/ovf/zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_core
    import ula_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ULA_OPW-1:0] ULAcontrole,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic               addsub,
    output logic [WIDTH-1:0]   ULAsaida,
    output logic               cout,
    output logic               ovf,
    output logic               zero
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_slice_r;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;

    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        ula_bit_slice u_slice (
            .op     (ULAcontrole),
            .a_i    (a[i]),
            .b_i    (b[i]),
            .c_i    (w_carry[i]),
            .addsub (addsub),
            .r_i    (w_slice_r[i]),
            .c_o    (w_carry[i+1]),
            .s_i    (w_sum[i])
        );
    end

    // For WIDTH=1 this collapses to cout ^ cin, since w_carry[0] is cin.
    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_comb begin
        w_result = w_slice_r;
        if (ula_op_e'(ULAcontrole) == OP_SLT) begin
            w_result    = '0;
            w_result[0] = w_sum[WIDTH-1] ^ w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_result <= w_result;
            r_cout   <= w_carry[WIDTH];
            r_ovf    <= w_ovf;
            r_zero   <= (w_result == '0);
        end
    end

    assign ULAsaida = r_result;
    assign cout     = r_cout;
    assign ovf      = r_ovf;
    assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_ula_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_core
// Description : Self-checking bench for ula_core at WIDTH=1 and WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_core;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin;
    logic       addsub;

    logic       res1;
    logic       c1, v1, z1;
    logic [3:0] res4;
    logic       c4, v4, z4;

    int checks = 0;
    int errors = 0;

    exp_t e1, e4;
    logic valid = 1'b0;

    always #5 clk = ~clk;

    ula_core #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .ULAcontrole(op), .a(a4[0]), .b(b4[0]),
        .cin(cin), .addsub(addsub), .ULAsaida(res1), .cout(c1), .ovf(v1), .zero(z1)
    );

    ula_core #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .ULAcontrole(op), .a(a4), .b(b4),
        .cin(cin), .addsub(addsub), .ULAsaida(res4), .cout(c4), .ovf(v4), .zero(z4)
    );

    // Arithmetic reference: integer sums and masks, signed overflow from the
    // carry into the MSB versus the carry out of it.
    function automatic exp_t model(int w, logic [2:0] o, logic [63:0] av,
                                   logic [63:0] bv, logic ci, logic as);
        exp_t        r;
        logic [64:0] mask, m1, bb, full, low;
        logic [63:0] sum;
        logic        cm1;
        mask = (65'd1 << w) - 65'd1;
        m1   = mask >> 1;
        av   = av & mask[63:0];
        bv   = bv & mask[63:0];
        bb   = as ? (~{1'b0, bv} & mask) : {1'b0, bv};
        full = {1'b0, av} + bb + {64'd0, ci};
        low  = ({1'b0, av} & m1) + (bb & m1) + {64'd0, ci};
        sum  = full[63:0] & mask[63:0];
        r.c  = full[w];
        cm1  = low[w-1];
        r.v  = r.c ^ cm1;
        case (o)
            3'd0:    r.res = av & bv;
            3'd1:    r.res = av | bv;
            3'd2:    r.res = sum;
            3'd3:    r.res = av ^ bv;
            3'd4:    r.res = ~(av | bv) & mask[63:0];
            3'd5:    r.res = ~(av & bv) & mask[63:0];
            3'd6:    r.res = av;
            default: r.res = {63'd0, sum[w-1] ^ r.v};
        endcase
        r.z = (r.res == 64'd0);
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            e1 = '{res: 64'd0, c: 1'b0, v: 1'b0, z: 1'b0};
            e4 = e1;
        end else begin
            e1 = model(1, op, {63'd0, a4[0]}, {63'd0, b4[0]}, cin, addsub);
            e4 = model(4, op, {60'd0, a4}, {60'd0, b4}, cin, addsub);
        end
        valid = 1'b1;
    end

    always @(negedge clk) begin
        if (valid) begin
            check("w1_res",  {63'd0, res1}, e1.res);
            check("w1_cout", {63'd0, c1},   {63'd0, e1.c});
            check("w1_ovf",  {63'd0, v1},   {63'd0, e1.v});
            check("w1_zero", {63'd0, z1},   {63'd0, e1.z});
            check("w4_res",  {60'd0, res4}, e4.res);
            check("w4_cout", {63'd0, c4},   {63'd0, e4.c});
            check("w4_ovf",  {63'd0, v4},   {63'd0, e4.v});
            check("w4_zero", {63'd0, z4},   {63'd0, e4.z});
        end
    end

    task automatic drive(logic [2:0] o, logic [3:0] av, logic [3:0] bv,
                         logic ci, logic as);
        @(negedge clk);
        op = o; a4 = av; b4 = bv; cin = ci; addsub = as;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lops [6] = '{0, 1, 3, 4, 5, 6};
        int l10  [6] = '{0, 1, 1, 0, 1, 1};

        rst = 1'b1; op = 3'd0; a4 = 4'd1; b4 = 4'd1; cin = 1'b0; addsub = 1'b0;
        @(posedge clk);
        #1;
        check("rst_res1", {63'd0, res1}, 64'd0);
        check("rst_res4", {60'd0, res4}, 64'd0);
        check("rst_flags", {60'd0, c4, v4, z4, z1}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_res1", {63'd0, res1}, 64'd1);
        check("post_rst_res4", {60'd0, res4}, 64'd1);

        for (int k = 0; k < 6; k++)
            for (int av = 0; av < 2; av++)
                for (int bv = 0; bv < 2; bv++) begin
                    drive(3'(lops[k]), 4'(av), 4'(bv), 1'b0, 1'b0);
                    if (av == 1 && bv == 0)
                        check("logic_a1b0", {63'd0, res1}, 64'(l10[k]));
                end

        drive(3'd2, 4'd1, 4'd1, 1'b1, 1'b0);
        check("add111_res", {63'd0, res1}, 64'd1);
        check("add111_cout", {63'd0, c1}, 64'd1);
        drive(3'd2, 4'd1, 4'd1, 1'b0, 1'b0);
        check("add110_res", {62'd0, c1, res1}, 64'd2);
        check("add110_zero", {63'd0, z1}, 64'd1);
        drive(3'd2, 4'd1, 4'd1, 1'b1, 1'b1);
        check("sub111_res", {62'd0, c1, res1}, 64'd2);
        check("sub111_zero", {63'd0, z1}, 64'd1);
        drive(3'd2, 4'd0, 4'd1, 1'b0, 1'b1);
        check("sub010_res", {62'd0, c1, res1}, 64'd0);

        drive(3'd2, 4'd7, 4'd1, 1'b0, 1'b0);
        check("w4_7p1_res", {60'd0, res4}, 64'd8);
        check("w4_7p1_ovf", {63'd0, v4}, 64'd1);
        drive(3'd7, 4'd3, 4'd5, 1'b1, 1'b1);
        check("w4_slt35", {60'd0, res4}, 64'd1);
        drive(3'd7, 4'd5, 4'd3, 1'b1, 1'b1);
        check("w4_slt53", {60'd0, res4}, 64'd0);

        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 15) == 0);
            op     = 3'($urandom_range(0, 7));
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            cin    = 1'($urandom);
            addsub = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
